// File: rtl/pong_pkg.sv
// Shared encodings for the PONG score keeper: FSM states, winner codes, score width.
package pong_pkg;

    localparam int SCORE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        NONE = 2'b00,
        P1   = 2'b01,
        P2   = 2'b10
    } winner_t;

endpackage

// File: rtl/score_flash_timer.sv
// Half-period timer for the winner's digit flash. While i_EN is low the timer
// is parked: counter at zero and o_FLASH at 1 (digit shown). While enabled,
// o_FLASH inverts once every FLASH_CYCLES clocks.
module score_flash_timer #(
    parameter int FLASH_CYCLES = 12500000
) (
    input  logic i_CLK,
    input  logic i_RST,
    input  logic i_EN,
    output logic o_FLASH
);

    localparam int CNT_W = (FLASH_CYCLES > 2) ? $clog2(FLASH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FLASH_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    // Count enabled cycles; wrap and toggle on the last one of each half-period
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            cnt     <= '0;
            o_FLASH <= 1'b1;
        end else if (!i_EN) begin
            cnt     <= '0;
            o_FLASH <= 1'b1;
        end else if (cnt == LAST) begin
            cnt     <= '0;
            o_FLASH <= ~o_FLASH;
        end else begin
            cnt     <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pong_score_keeper.sv
// PONG score keeper: start-edge detection, IDLE/PLAY/OVER game FSM, per-player
// scores, winner latch and the winner-digit flash in OVER.
module pong_score_keeper
    import pong_pkg::*;
#(
    parameter int WIN_SCORE    = 9,
    parameter int FLASH_CYCLES = 12500000
) (
    input  logic               i_CLK,
    input  logic               i_RST,
    input  logic               i_START,
    input  logic               i_P1_POINT,
    input  logic               i_P2_POINT,
    output logic [SCORE_W-1:0] o_P1_SCORE,
    output logic [SCORE_W-1:0] o_P2_SCORE,
    output logic               o_P1_DISP_EN,
    output logic               o_P2_DISP_EN,
    output logic               o_GAME_ACTIVE,
    output logic               o_SERVE,
    output logic [1:0]         o_WINNER
);

    localparam logic [SCORE_W-1:0] WIN_VAL = SCORE_W'(WIN_SCORE);

    state_t             state_q, state_d;
    winner_t            winner_q, winner_d;
    logic [SCORE_W-1:0] p1_q, p1_d, p2_q, p2_d, inc;
    logic               serve_q, serve_d;
    logic               active_q;
    logic               start_prev, armed;
    logic               start_edge;
    logic               flash_en, flash;

    // A start level already high when reset releases must not look like an
    // edge: 'armed' blocks edge detection until start_prev has sampled once.
    assign start_edge = armed & i_START & ~start_prev;

    // Start-edge history and arming flag
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            start_prev <= 1'b0;
            armed      <= 1'b0;
        end else begin
            start_prev <= i_START;
            armed      <= 1'b1;
        end
    end

    // Next-state, score, winner and serve decode
    always_comb begin
        state_d  = state_q;
        winner_d = winner_q;
        p1_d     = p1_q;
        p2_d     = p2_q;
        serve_d  = 1'b0;
        inc      = (i_P1_POINT ? p1_q : p2_q) + 1'b1;
        if (start_edge) begin
            // Start wins over any point pulse and restarts from any state
            state_d  = PLAY;
            winner_d = NONE;
            p1_d     = '0;
            p2_d     = '0;
            serve_d  = 1'b1;
        end else begin
            case (state_q)
                PLAY: begin
                    // Simultaneous points cancel out; exactly one scores
                    if (i_P1_POINT ^ i_P2_POINT) begin
                        if (i_P1_POINT) p1_d = inc;
                        else            p2_d = inc;
                        if (inc == WIN_VAL) begin
                            state_d  = OVER;
                            winner_d = i_P1_POINT ? P1 : P2;
                        end else begin
                            serve_d  = 1'b1;
                        end
                    end
                end
                IDLE, OVER: ;
                default: state_d = IDLE;
            endcase
        end
    end

    // Game state and output registers
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state_q  <= IDLE;
            winner_q <= NONE;
            p1_q     <= '0;
            p2_q     <= '0;
            serve_q  <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
            p1_q     <= p1_d;
            p2_q     <= p2_d;
            serve_q  <= serve_d;
            active_q <= (state_d == PLAY);
        end
    end

    // Timer runs only on cycles that stay in OVER, so it starts counting the
    // cycle after entry and is parked on the same edge that leaves OVER.
    assign flash_en = (state_q == OVER) && (state_d == OVER);

    score_flash_timer #(
        .FLASH_CYCLES(FLASH_CYCLES)
    ) u_flash (
        .i_CLK  (i_CLK),
        .i_RST  (i_RST),
        .i_EN   (flash_en),
        .o_FLASH(flash)
    );

    assign o_P1_SCORE    = p1_q;
    assign o_P2_SCORE    = p2_q;
    assign o_WINNER      = winner_q;
    assign o_SERVE       = serve_q;
    assign o_GAME_ACTIVE = active_q;
    // flash is parked high outside OVER and winner_q is static inside it,
    // so each enable is a clean copy of a register.
    assign o_P1_DISP_EN  = (winner_q != P1) | flash;
    assign o_P2_DISP_EN  = (winner_q != P2) | flash;

endmodule

// File: tb/tb_pong_score_keeper.sv
// Directed bench for pong_score_keeper with a behavioural model feeding a
// scoreboard of expected outputs, checked half a cycle after each edge.
module tb_pong_score_keeper;

    localparam int WIN   = 6;
    localparam int FLASH = 4;

    logic       i_CLK = 1'b0;
    logic       i_RST = 1'b1;
    logic       i_START = 1'b0, i_P1_POINT = 1'b0, i_P2_POINT = 1'b0;
    logic [3:0] o_P1_SCORE, o_P2_SCORE;
    logic       o_P1_DISP_EN, o_P2_DISP_EN, o_GAME_ACTIVE, o_SERVE;
    logic [1:0] o_WINNER;

    pong_score_keeper #(.WIN_SCORE(WIN), .FLASH_CYCLES(FLASH)) dut (
        .i_CLK(i_CLK), .i_RST(i_RST), .i_START(i_START),
        .i_P1_POINT(i_P1_POINT), .i_P2_POINT(i_P2_POINT),
        .o_P1_SCORE(o_P1_SCORE), .o_P2_SCORE(o_P2_SCORE),
        .o_P1_DISP_EN(o_P1_DISP_EN), .o_P2_DISP_EN(o_P2_DISP_EN),
        .o_GAME_ACTIVE(o_GAME_ACTIVE), .o_SERVE(o_SERVE), .o_WINNER(o_WINNER)
    );

    always #5 i_CLK = ~i_CLK;

    typedef struct {
        logic [3:0] p1, p2;
        logic       en1, en2, act, srv;
        logic [1:0] win;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0, n_pass = 0;
    int   serves_seen = 0;

    // behavioural model state
    int m_state = 0, m_p1 = 0, m_p2 = 0, m_win = 0, m_over = 0;
    bit m_prev = 0, m_armed = 0, m_srv = 0;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_state = 0; m_p1 = 0; m_p2 = 0; m_win = 0; m_over = 0;
        m_prev = 0; m_armed = 0; m_srv = 0;
    endtask

    task automatic model(input bit s, input bit a, input bit b);
        bit e;
        e = m_armed && s && !m_prev;
        m_prev = s; m_armed = 1; m_srv = 0;
        if (e) begin
            m_state = 1; m_p1 = 0; m_p2 = 0; m_win = 0; m_srv = 1; m_over = 0;
        end else if (m_state == 1 && a != b) begin
            if (a) m_p1 = m_p1 + 1; else m_p2 = m_p2 + 1;
            if (m_p1 == WIN)      begin m_state = 2; m_win = 1; m_over = 0; end
            else if (m_p2 == WIN) begin m_state = 2; m_win = 2; m_over = 0; end
            else m_srv = 1;
        end else if (m_state == 2) begin
            m_over = m_over + 1;
        end
    endtask

    function automatic exp_t model_out();
        exp_t x;
        bit   lit;
        lit   = ((m_over / FLASH) % 2) == 0;
        x.p1  = 4'(m_p1);
        x.p2  = 4'(m_p2);
        x.win = 2'(m_win);
        x.act = (m_state == 1);
        x.srv = m_srv;
        x.en1 = (m_state == 2 && m_win == 1) ? lit : 1'b1;
        x.en2 = (m_state == 2 && m_win == 2) ? lit : 1'b1;
        return x;
    endfunction

    // drive one cycle, push the model's expectation, compare after the edge
    task automatic cyc(input bit s, input bit a, input bit b);
        exp_t x;
        i_START = s; i_P1_POINT = a; i_P2_POINT = b;
        model(s, a, b);
        q.push_back(model_out());
        @(posedge i_CLK);
        @(negedge i_CLK);
        if (q.size() == 0) begin
            n_chk++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            x = q.pop_front();
            chk("p1_score", o_P1_SCORE, x.p1);
            chk("p2_score", o_P2_SCORE, x.p2);
            chk("winner", {2'b0, o_WINNER}, {2'b0, x.win});
            chk("active", {3'b0, o_GAME_ACTIVE}, {3'b0, x.act});
            chk("serve", {3'b0, o_SERVE}, {3'b0, x.srv});
            chk("p1_en", {3'b0, o_P1_DISP_EN}, {3'b0, x.en1});
            chk("p2_en", {3'b0, o_P2_DISP_EN}, {3'b0, x.en2});
        end
        if (o_SERVE === 1'b1) serves_seen++;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_p1"}, o_P1_SCORE, 4'd0);
        chk({tag, "_p2"}, o_P2_SCORE, 4'd0);
        chk({tag, "_win"}, {2'b0, o_WINNER}, 4'd0);
        chk({tag, "_act"}, {3'b0, o_GAME_ACTIVE}, 4'd0);
        chk({tag, "_srv"}, {3'b0, o_SERVE}, 4'd0);
        chk({tag, "_en1"}, {3'b0, o_P1_DISP_EN}, 4'd1);
        chk({tag, "_en2"}, {3'b0, o_P2_DISP_EN}, 4'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        model_reset();
        repeat (2) @(posedge i_CLK);
        @(negedge i_CLK);
        chk_reset_outputs("reset");
        i_RST = 1'b0;

        // points in IDLE are ignored
        for (int i = 0; i < 3; i++) begin cyc(0, 1, 0); cyc(0, 0, 0); end

        // start, then P1 x2 and P2 x1: four serves total
        serves_seen = 0;
        cyc(1, 0, 0); cyc(0, 0, 0);
        cyc(0, 1, 0); cyc(0, 0, 0);
        cyc(0, 1, 0); cyc(0, 0, 1); cyc(0, 0, 0);
        chk("serve_count_play", 4'(serves_seen), 4'd4);

        // simultaneous points are discarded
        cyc(0, 1, 1); cyc(0, 0, 0);

        // P2 runs to WIN, then flash and ignored pulses in OVER
        for (int i = 0; i < WIN - 1; i++) begin cyc(0, 0, 1); cyc(0, 0, 0); end
        for (int i = 0; i < 3 * FLASH + 1; i++) cyc(0, 0, 0);
        cyc(0, 1, 0); cyc(0, 0, 1); cyc(0, 1, 1);
        for (int i = 0; i < FLASH; i++) cyc(0, 0, 0);

        // hold start for 10 cycles in OVER: exactly one restart
        serves_seen = 0;
        for (int i = 0; i < 10; i++) cyc(1, 0, 0);
        cyc(0, 0, 0);
        chk("serve_count_restart", 4'(serves_seen), 4'd1);

        // start has priority over a point in the same cycle
        cyc(1, 1, 0); cyc(0, 0, 0);

        // reach 5/4 then assert reset asynchronously mid-cycle
        for (int i = 0; i < 5; i++) cyc(0, 1, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1);
        @(posedge i_CLK);
        #2;
        i_RST = 1'b1;
        i_START = 1'b1; i_P1_POINT = 1'b0; i_P2_POINT = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        model_reset();
        q.delete();
        @(negedge i_CLK);
        i_RST = 1'b0;

        // start already high at release must not start a game
        for (int i = 0; i < 4; i++) cyc(1, 0, 0);
        cyc(0, 0, 0);
        cyc(1, 0, 0); cyc(0, 0, 0);
        cyc(0, 0, 1); cyc(0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
